// File: rtl/inst_rom_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_loader_if
// Brief    : CPU fetch port plus byte-stream loader port of the instruction ROM.
// Revision : 1.0
// ============================================================================
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic [31:0]           inst;
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  ld_done;
    logic [DEPTH_LOG2:0]   ld_words;
    logic                  cpu_hold;

    modport master (
        output ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        input  inst, ld_ready, ld_done, ld_words, cpu_hold
    );

    modport slave (
        input  ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        output inst, ld_ready, ld_done, ld_words, cpu_hold
    );
endinterface
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_loader
// Brief    : Instruction ROM filled from a big-endian byte stream, then served
//            to the CPU fetch stage with zero latency while the core runs.
// Revision : 1.0
// ============================================================================
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_rom_loader_if.slave      bus
);
    localparam logic [DEPTH_LOG2:0] c_WORDS_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEPTH_LOG2:0]     r_words;
    logic [1:0]              r_bcnt;
    logic [23:0]             r_part;
    logic [31:0]             r_mem [0:(1 << DEPTH_LOG2) - 1];

    logic                    w_accept;
    logic                    w_word_end;
    logic [31:0]             w_word_asm;
    logic [DEPTH_LOG2:0]     w_words_inc;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_hit;
    logic                    w_ready;
    logic                    w_done;
    logic                    w_hold;

    // A start pulse always wins over a byte offered in the same cycle.
    assign w_accept    = (r_state == S_LOAD) && bus.ld_valid && !bus.ld_start;
    assign w_word_end  = w_accept && ((r_bcnt == 2'd3) || bus.ld_last);
    assign w_words_inc = r_words + {{DEPTH_LOG2{1'b0}}, 1'b1};

    always_comb begin
        w_word_asm = 32'h0;
        case (r_bcnt)
            2'd0:    w_word_asm = {bus.ld_byte, 24'h0};
            2'd1:    w_word_asm = {r_part[23:16], bus.ld_byte, 16'h0};
            2'd2:    w_word_asm = {r_part[23:8], bus.ld_byte, 8'h0};
            default: w_word_asm = {r_part, bus.ld_byte};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_hold      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.ld_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (bus.ld_start) begin
                    w_state_nxt = S_LOAD;
                end else if (w_word_end && (bus.ld_last || (w_words_inc == c_WORDS_FULL))) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_done = 1'b1;
                w_hold = 1'b0;
                if (bus.ld_start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The word count doubles as the write pointer; it stops at full depth
    // because the FSM leaves LOAD on the write that fills the last word.
    always_ff @(posedge clk) begin
        if (rst || bus.ld_start) begin
            r_words <= '0;
            r_bcnt  <= 2'd0;
            r_part  <= 24'h0;
        end else if (w_word_end) begin
            r_words <= w_words_inc;
            r_bcnt  <= 2'd0;
            r_part  <= 24'h0;
        end else if (w_accept) begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_part  <= w_word_asm[31:8];
        end
    end

    // Storage keeps its contents through reset; r_words alone gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && w_word_end) begin
            r_mem[r_words[DEPTH_LOG2-1:0]] <= w_word_asm;
        end
    end

    assign w_idx = bus.addr[DEPTH_LOG2+1:2];
    assign w_hit = (r_state == S_RUN) && bus.ce
                && ((bus.addr >> (DEPTH_LOG2 + 2)) == 32'd0)
                && ({1'b0, w_idx} < r_words);

    assign bus.inst     = w_hit ? r_mem[w_idx] : 32'h0;
    assign bus.ld_ready = w_ready;
    assign bus.ld_done  = w_done;
    assign bus.cpu_hold = w_hold;
    assign bus.ld_words = r_words;
endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_rom_loader
// Brief    : Self-checking bench driving a 1024-word and a 4-word loader in
//            lockstep against a byte-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_inst_rom_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        drv_ce;
    logic [31:0] drv_addr;
    logic        drv_start;
    logic        drv_valid;
    logic [7:0]  drv_byte;
    logic        drv_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_rom_loader_if #(.DEPTH_LOG2(10)) bus_b ();
    inst_rom_loader_if #(.DEPTH_LOG2(2))  bus_s ();

    assign bus_b.ce = drv_ce;       assign bus_s.ce = drv_ce;
    assign bus_b.addr = drv_addr;   assign bus_s.addr = drv_addr;
    assign bus_b.ld_start = drv_start; assign bus_s.ld_start = drv_start;
    assign bus_b.ld_valid = drv_valid; assign bus_s.ld_valid = drv_valid;
    assign bus_b.ld_byte = drv_byte;   assign bus_s.ld_byte = drv_byte;
    assign bus_b.ld_last = drv_last;   assign bus_s.ld_last = drv_last;

    inst_rom_loader #(.DEPTH_LOG2(10)) u_big   (.clk(clk), .rst(rst), .bus(bus_b));
    inst_rom_loader #(.DEPTH_LOG2(2))  u_small (.clk(clk), .rst(rst), .bus(bus_s));

    // Reference model: index 0 = 1024-word device, index 1 = 4-word device.
    logic [31:0] m_mem [2][1024];
    int          m_depth [2] = '{1024, 4};
    int          m_words [2] = '{0, 0};
    int          m_nbytes[2] = '{0, 0};
    bit          m_loading[2] = '{1'b0, 1'b0};
    bit          m_done  [2] = '{1'b0, 1'b0};
    logic [31:0] m_cur   [2] = '{32'h0, 32'h0};

    task automatic model_step(input int k);
        if (rst) begin
            m_loading[k] = 1'b0; m_done[k] = 1'b0; m_words[k] = 0;
        end else if (drv_start) begin
            m_loading[k] = 1'b1; m_done[k] = 1'b0; m_words[k] = 0;
            m_nbytes[k] = 0; m_cur[k] = 32'h0;
        end else if (m_loading[k] && drv_valid) begin
            m_cur[k] = m_cur[k] | ({24'h0, drv_byte} << (8 * (3 - (m_nbytes[k] % 4))));
            m_nbytes[k]++;
            if ((m_nbytes[k] % 4 == 0) || drv_last) begin
                m_mem[k][m_words[k]] = m_cur[k];
                m_words[k]++;
                m_cur[k] = 32'h0;
                if (drv_last || m_words[k] == m_depth[k]) begin
                    m_loading[k] = 1'b0; m_done[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_inst(input int k);
        if (m_done[k] && drv_ce && (drv_addr < 32'(m_depth[k] * 4))
            && (int'(drv_addr / 4) < m_words[k]))
            return m_mem[k][drv_addr / 4];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("b_ready", {31'b0, bus_b.ld_ready}, {31'b0, m_loading[0]});
        chk("b_done",  {31'b0, bus_b.ld_done},  {31'b0, m_done[0]});
        chk("b_hold",  {31'b0, bus_b.cpu_hold}, {31'b0, !m_done[0]});
        chk("b_words", 32'(bus_b.ld_words), 32'(m_words[0]));
        chk("b_inst",  bus_b.inst, exp_inst(0));
        chk("s_ready", {31'b0, bus_s.ld_ready}, {31'b0, m_loading[1]});
        chk("s_done",  {31'b0, bus_s.ld_done},  {31'b0, m_done[1]});
        chk("s_hold",  {31'b0, bus_s.cpu_hold}, {31'b0, !m_done[1]});
        chk("s_words", 32'(bus_s.ld_words), 32'(m_words[1]));
        chk("s_inst",  bus_s.inst, exp_inst(1));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic peek(input logic [31:0] a);
        drv_addr = a;
        #1;
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        drv_valid = 1'b1; drv_byte = b; drv_last = last;
        cycle();
        drv_valid = 1'b0; drv_last = 1'b0;
    endtask

    task automatic pulse_start();
        drv_start = 1'b1;
        cycle();
        drv_start = 1'b0;
    endtask

    typedef struct {
        bit          rst, start, valid, last, ce;
        logic [7:0]  b;
        logic [31:0] addr;
        bit          e_ready, e_done, e_hold;
        int          e_words;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit v, logic [7:0] b, bit l, bit c,
                                logic [31:0] a, bit er, bit ed, bit eh, int ew,
                                logic [31:0] ei);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.b = b; t.last = l; t.ce = c;
        t.addr = a; t.e_ready = er; t.e_done = ed; t.e_hold = eh;
        t.e_words = ew; t.e_inst = ei;
        return t;
    endfunction

    vec_t tbl [14];

    initial begin
        rst = 1'b1; drv_ce = 1'b0; drv_addr = 32'h0; drv_start = 1'b0;
        drv_valid = 1'b0; drv_byte = 8'h0; drv_last = 1'b0;

        //            rst st vl byte  lst ce addr          rdy dn hold wds inst
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 1, 32'h0,        0, 0, 1, 0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 8'h00, 0, 1, 32'h0,        1, 0, 1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 1, 8'h34, 0, 1, 32'h0,        1, 0, 1, 0, 32'h0);
        tbl[3]  = mk(0, 0, 1, 8'h01, 0, 1, 32'h0,        1, 0, 1, 0, 32'h0);
        tbl[4]  = mk(0, 0, 1, 8'h00, 0, 1, 32'h0,        1, 0, 1, 0, 32'h0);
        tbl[5]  = mk(0, 0, 1, 8'h01, 0, 1, 32'h0,        1, 0, 1, 1, 32'h0);
        tbl[6]  = mk(0, 0, 1, 8'h34, 0, 1, 32'h0,        1, 0, 1, 1, 32'h0);
        tbl[7]  = mk(0, 0, 1, 8'h02, 0, 1, 32'h0,        1, 0, 1, 1, 32'h0);
        tbl[8]  = mk(0, 0, 1, 8'h00, 0, 1, 32'h0,        1, 0, 1, 1, 32'h0);
        tbl[9]  = mk(0, 0, 1, 8'h02, 1, 1, 32'h0,        0, 1, 0, 2, 32'h34010001);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 1, 32'h4,        0, 1, 0, 2, 32'h34020002);
        tbl[11] = mk(0, 0, 0, 8'h00, 0, 1, 32'h8,        0, 1, 0, 2, 32'h0);
        tbl[12] = mk(0, 0, 1, 8'h77, 0, 0, 32'h0,        0, 1, 0, 2, 32'h0);
        tbl[13] = mk(0, 0, 0, 8'h00, 0, 1, 32'h3,        0, 1, 0, 2, 32'h34010001);

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; drv_start = tbl[i].start; drv_valid = tbl[i].valid;
            drv_byte = tbl[i].b; drv_last = tbl[i].last; drv_ce = tbl[i].ce;
            drv_addr = tbl[i].addr;
            cycle();
            chk($sformatf("tbl%0d_ready", i), {31'b0, bus_b.ld_ready}, {31'b0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_done", i),  {31'b0, bus_b.ld_done},  {31'b0, tbl[i].e_done});
            chk($sformatf("tbl%0d_hold", i),  {31'b0, bus_b.cpu_hold}, {31'b0, tbl[i].e_hold});
            chk($sformatf("tbl%0d_words", i), 32'(bus_b.ld_words), 32'(tbl[i].e_words));
            chk($sformatf("tbl%0d_inst", i),  bus_b.inst, tbl[i].e_inst);
        end
        rst = 1'b0; drv_valid = 1'b0; drv_last = 1'b0; drv_ce = 1'b1;

        // Partial final word: unfilled low bytes read as zero.
        pulse_start();
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        send_byte(8'hDD, 0); send_byte(8'hEE, 1);
        chk("part_words", 32'(bus_b.ld_words), 32'd2);
        peek(32'h4); chk("part_inst4", bus_b.inst, 32'hEE000000);
        peek(32'h5); chk("part_inst5", bus_b.inst, 32'hEE000000);
        peek(32'h0); chk("part_inst0", bus_b.inst, 32'hAABBCCDD);

        // Capacity stop on the 4-word device with no ld_last.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1), 0);
            if (i == 15) begin
                chk("full_ready16", {31'b0, bus_s.ld_ready}, 32'd0);
                chk("full_done16",  {31'b0, bus_s.ld_done},  32'd1);
                chk("full_words16", 32'(bus_s.ld_words), 32'd4);
            end
        end
        chk("full_words20", 32'(bus_s.ld_words), 32'd4);
        peek(32'hC);  chk("full_instC", bus_s.inst, 32'h0D0E0F10);
        peek(32'h10); chk("full_inst10", bus_s.inst, 32'h0);

        // Reset in the middle of a load.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i), 0);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("abort_words", 32'(bus_b.ld_words), 32'd0);
        chk("abort_hold",  {31'b0, bus_b.cpu_hold}, 32'd1);
        peek(32'h0); chk("abort_inst0", bus_b.inst, 32'h0);
        peek(32'h4); chk("abort_inst4", bus_b.inst, 32'h0);
        cycle();

        // Restart from RUN with a byte on the start cycle; ce=0 blanks fetch.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
        drv_ce = 1'b0; peek(32'h0); chk("ce0_inst", bus_b.inst, 32'h0);
        drv_ce = 1'b1;
        drv_start = 1'b1; drv_valid = 1'b1; drv_byte = 8'h55;
        cycle();
        drv_start = 1'b0; drv_valid = 1'b0;
        chk("rs_done",  {31'b0, bus_b.ld_done},  32'd0);
        chk("rs_hold",  {31'b0, bus_b.cpu_hold}, 32'd1);
        chk("rs_words", 32'(bus_b.ld_words), 32'd0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
        peek(32'h0); chk("rs_inst0", bus_b.inst, 32'h11223344);

        // Reset outranks start and valid in the same cycle.
        rst = 1'b1; drv_start = 1'b1; drv_valid = 1'b1;
        cycle();
        rst = 1'b0; drv_start = 1'b0; drv_valid = 1'b0;
        chk("rstpri_ready", {31'b0, bus_b.ld_ready}, 32'd0);
        cycle();

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            drv_start = ($urandom_range(0, 24) == 0);
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_last  = ($urandom_range(0, 11) == 0);
            drv_byte  = 8'($urandom);
            drv_ce    = ($urandom_range(0, 7) != 0);
            drv_addr  = ($urandom_range(0, 15) == 0) ? 32'($urandom)
                                                     : 32'($urandom_range(0, 40));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
